// File: rtl/psa_seq_ctrl.sv
// Paired sub-word add sequencer: one 4-bit saturating adder slice walks the four nibbles LSB first.
// Optional PSA_SEQ_NIBBLE_OVFL_EN exposes per-nibble positive/negative saturation flags.
module psa_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Sum,
    output logic        Error
`ifdef PSA_SEQ_NIBBLE_OVFL_EN
    ,
    output logic [3:0]  pos_ovfl,
    output logic [3:0]  neg_ovfl
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [1:0]  cnt;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] sum_q;

    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [3:0]  s_nib;
    logic        pos_sat;
    logic        neg_sat;
    logic [3:0]  res_nib;

    // Shared adder slice, operand nibble selected by the sequence counter.
    always_comb begin
        a_nib   = a_reg[{cnt, 2'b00} +: 4];
        b_nib   = b_reg[{cnt, 2'b00} +: 4];
        s_nib   = a_nib + b_nib;
        pos_sat = ~a_nib[3] & ~b_nib[3] &  s_nib[3];
        neg_sat =  a_nib[3] &  b_nib[3] & ~s_nib[3];
        res_nib = s_nib;
        if (pos_sat)
            res_nib = 4'h7;
        else if (neg_sat)
            res_nib = 4'h8;
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign Sum       = sum_q;

`ifdef PSA_SEQ_NIBBLE_OVFL_EN
    logic [3:0] pos_q;
    logic [3:0] neg_q;
    assign pos_ovfl = pos_q;
    assign neg_ovfl = neg_q;
    assign Error    = |{pos_q, neg_q};
`else
    logic err_q;
    assign Error = err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
            a_reg <= 16'h0000;
            b_reg <= 16'h0000;
            sum_q <= 16'h0000;
`ifdef PSA_SEQ_NIBBLE_OVFL_EN
            pos_q <= 4'h0;
            neg_q <= 4'h0;
`else
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= A;
                        b_reg <= B;
                        cnt   <= 2'd0;
                        sum_q <= 16'h0000;
`ifdef PSA_SEQ_NIBBLE_OVFL_EN
                        pos_q <= 4'h0;
                        neg_q <= 4'h0;
`else
                        err_q <= 1'b0;
`endif
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    sum_q[{cnt, 2'b00} +: 4] <= res_nib;
`ifdef PSA_SEQ_NIBBLE_OVFL_EN
                    pos_q[cnt] <= pos_sat;
                    neg_q[cnt] <= neg_sat;
`else
                    err_q <= err_q | pos_sat | neg_sat;
`endif
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3)
                        state <= S_DONE;
                end
                S_DONE: begin
                    // No accept here: the result must be released before IDLE takes new work.
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psa_seq_ctrl.sv
// Self-checking bench for psa_seq_ctrl against a signed-arithmetic per-nibble saturation model.
module tb_psa_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic        Error;
`ifdef PSA_SEQ_NIBBLE_OVFL_EN
    logic [3:0]  pos_ovfl;
    logic [3:0]  neg_ovfl;
`endif

    int checks   = 0;
    int failures = 0;

    psa_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Error     (Error)
`ifdef PSA_SEQ_NIBBLE_OVFL_EN
        ,
        .pos_ovfl  (pos_ovfl),
        .neg_ovfl  (neg_ovfl)
`endif
    );

    always #5 clk = ~clk;

    // Reference: each nibble is a signed value in [-8,7]; the true sum is clamped to that range.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] s, output logic e,
                                  output logic [3:0] p, output logic [3:0] n);
        s = 16'h0000;
        p = 4'h0;
        n = 4'h0;
        for (int i = 0; i < 4; i++) begin
            int x;
            int y;
            int t;
            logic [3:0] an;
            logic [3:0] bn;
            an = a[i*4 +: 4];
            bn = b[i*4 +: 4];
            x = (an >= 4'd8) ? int'(an) - 16 : int'(an);
            y = (bn >= 4'd8) ? int'(bn) - 16 : int'(bn);
            t = x + y;
            if (t > 7) begin
                t = 7;
                p[i] = 1'b1;
            end else if (t < -8) begin
                t = -8;
                n[i] = 1'b1;
            end
            s[i*4 +: 4] = t[3:0];
        end
        e = |{p, n};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Sum !== 16'h0000 || Error !== 1'b0) begin
            failures++;
            $display("FAIL %s: in_ready=%b out_valid=%b Sum=%h Error=%b, want 1 0 0000 0",
                     tag, in_ready, out_valid, Sum, Error);
        end
`ifdef PSA_SEQ_NIBBLE_OVFL_EN
        checks++;
        if (pos_ovfl !== 4'h0 || neg_ovfl !== 4'h0) begin
            failures++;
            $display("FAIL %s_ovfl: pos=%b neg=%b, want 0000 0000", tag, pos_ovfl, neg_ovfl);
        end
`endif
    endtask

    // One operation; hold = cycles of out_ready=0 in DONE while in_valid/A/B are scrambled.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold, input string tag);
        logic [15:0] es;
        logic        ee;
        logic [3:0]  ep;
        logic [3:0]  en;
        int          lat;
        model(a, b, es, ee, ep, en);
        @(negedge clk);
        A = a;
        B = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        step();
        @(negedge clk);
        in_valid = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_accept: in_ready=%b want 0", tag, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles want 4", tag, lat);
        end
        checks++;
        if (Sum !== es || Error !== ee) begin
            failures++;
            $display("FAIL %s_result: Sum=%h Error=%b want Sum=%h Error=%b", tag, Sum, Error, es, ee);
        end
`ifdef PSA_SEQ_NIBBLE_OVFL_EN
        checks++;
        if (pos_ovfl !== ep || neg_ovfl !== en) begin
            failures++;
            $display("FAIL %s_ovfl: pos=%b neg=%b want pos=%b neg=%b", tag, pos_ovfl, neg_ovfl, ep, en);
        end
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            A = 16'($urandom);
            B = 16'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Sum !== es || Error !== ee) begin
                failures++;
                $display("FAIL %s_hold%0d: out_valid=%b in_ready=%b Sum=%h Error=%b want 1 0 %h %b",
                         tag, h, out_valid, in_ready, Sum, Error, es, ee);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || Sum !== es || Error !== ee) begin
            failures++;
            $display("FAIL %s_release: in_ready=%b out_valid=%b Sum=%h Error=%b want 1 0 %h %b",
                     tag, in_ready, out_valid, Sum, Error, es, ee);
        end
        // Result stays put in IDLE until the next accept.
        step();
        checks++;
        if (in_ready !== 1'b1 || Sum !== es || Error !== ee) begin
            failures++;
            $display("FAIL %s_idle_hold: in_ready=%b Sum=%h Error=%b want 1 %h %b",
                     tag, in_ready, Sum, Error, es, ee);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = 16'h0;
        B = 16'h0;
        step();
        step();
        check_idle_reset("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h1111, 0, "basic");
        run_op(16'h7777, 16'h1111, 0, "pos_sat");
        run_op(16'h8888, 16'hFFFF, 0, "neg_sat");
        run_op(16'h7F82, 16'h1F81, 0, "mixed");
    endtask

    task automatic test_backpressure();
        run_op(16'h7F82, 16'h1F81, 3, "backpressure");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        A = 16'h7777;
        B = 16'h7777;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        in_valid = 1'b0;
        step();
        step();
        // Counter is at nibble 2; reset together with a fresh request.
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check_idle_reset("reset_mid");
        step();
        check_idle_reset("reset_mid_noaccept");
        run_op(16'h1234, 16'h1111, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
